// File: rtl/spi_controller.sv
// Single-byte SPI master, mode 0, MSB first. Frames one byte with ss, shifts
// tx_data out on mosi while capturing miso, then pulses done with the result.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int              DW       = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [3:0]    half_cnt, half_nxt;
  logic [6:0]    tx_sr, tx_nxt;
  logic [7:0]    rx_sr, rx_sr_nxt;
  logic [7:0]    rx_data_nxt;
  logic          busy_nxt, done_nxt, ss_nxt, sclk_nxt, mosi_nxt;
  logic          div_tc, accept;

  // tx_sr only holds bits 6..0; bit 7 goes straight onto mosi at accept
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    half_nxt    = half_cnt;
    tx_nxt      = tx_sr;
    rx_sr_nxt   = rx_sr;
    rx_data_nxt = rx_data;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    ss_nxt      = ss;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    div_tc      = (div_cnt == DIV_LAST);
    accept      = 1'b0;

    unique case (state)
      IDLE: begin
        accept = start;
      end

      SETUP: begin
        if (div_tc) begin
          div_nxt   = '0;
          half_nxt  = '0;
          state_nxt = SHIFT;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      SHIFT: begin
        if (div_tc) begin
          div_nxt = '0;
          if (!half_cnt[0]) begin
            sclk_nxt  = 1'b1;
            rx_sr_nxt = {rx_sr[6:0], miso};
            half_nxt  = half_cnt + 4'd1;
          end else begin
            sclk_nxt = 1'b0;
            if (half_cnt == 4'd15) begin
              // last falling edge: mosi keeps bit 0 through HOLD
              half_nxt  = '0;
              state_nxt = HOLD;
            end else begin
              mosi_nxt = tx_sr[6];
              tx_nxt   = {tx_sr[5:0], 1'b0};
              half_nxt = half_cnt + 4'd1;
            end
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      HOLD: begin
        if (div_tc) begin
          div_nxt     = '0;
          ss_nxt      = 1'b1;
          rx_data_nxt = rx_sr;
          done_nxt    = 1'b1;
          state_nxt   = GAP;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      GAP: begin
        if (div_tc) begin
          div_nxt = '0;
          // the GAP exit edge is the first IDLE sampling point, so a held
          // start restarts with ss high for exactly CLK_DIV cycles
          if (start) begin
            accept = 1'b1;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (accept) begin
      tx_nxt    = tx_data[6:0];
      mosi_nxt  = tx_data[7];
      ss_nxt    = 1'b0;
      busy_nxt  = 1'b1;
      div_nxt   = '0;
      half_nxt  = '0;
      state_nxt = SETUP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      half_cnt <= half_nxt;
      tx_sr    <= tx_nxt;
      rx_sr    <= rx_sr_nxt;
      rx_data  <= rx_data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      ss       <= ss_nxt;
      sclk     <= sclk_nxt;
      mosi     <= mosi_nxt;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: three instances (CLK_DIV 2, 4, 1), a mode-0
// peripheral model on the CLK_DIV=4 one, loopback on the others.
module tb_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [2:0] start;
  logic [7:0] tx_data [3];
  wire  [7:0] rx_data [3];
  wire  [2:0] busy, done, ss, sclk, mosi, miso;
  logic       p_miso;
  logic [7:0] p_tx, p_rx;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_controller #(.CLK_DIV(g == 0 ? 2 : (g == 1 ? 4 : 1))) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .start   (start[g]),
      .tx_data (tx_data[g]),
      .rx_data (rx_data[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .ss      (ss[g]),
      .sclk    (sclk[g]),
      .mosi    (mosi[g]),
      .miso    (miso[g])
    );
  end

  assign miso[0] = mosi[0];
  assign miso[1] = p_miso;
  assign miso[2] = mosi[2];

  // mode-0 peripheral answering 8'h3C
  always @(negedge ss[1]) begin
    p_tx   = 8'h3C;
    p_miso = p_tx[7];
  end
  always @(posedge sclk[1]) p_rx = {p_rx[6:0], mosi[1]};
  always @(negedge sclk[1]) begin
    p_tx   = {p_tx[6:0], 1'b0};
    p_miso = p_tx[7];
  end

  function automatic int div_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 4 : 1);
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q [3][$];
  int ss_low_run [3], last_ss_low [3], ss_high_run [3], last_ss_high [3];
  int busy_run [3], last_busy [3], rises [3], done_cnt [3];
  int bad_edge [3], bad_high [3], hi_run [3], first_rise [3], last_fall [3];
  logic [7:0] mosi_seq [3];
  logic prev_ss [3], prev_sclk [3];
  int cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (!ss[g]) ss_low_run[g]++;
      else if (ss_low_run[g] > 0) begin last_ss_low[g] = ss_low_run[g]; ss_low_run[g] = 0; end
      if (ss[g]) ss_high_run[g]++;
      else if (ss_high_run[g] > 0) begin last_ss_high[g] = ss_high_run[g]; ss_high_run[g] = 0; end
      if (busy[g]) busy_run[g]++;
      else if (busy_run[g] > 0) begin last_busy[g] = busy_run[g]; busy_run[g] = 0; end
      if (sclk[g] && !prev_sclk[g]) begin
        rises[g]++;
        if (rises[g] == 1) first_rise[g] = cyc;
        mosi_seq[g] = {mosi_seq[g][6:0], mosi[g]};
      end
      if (!sclk[g] && prev_sclk[g]) begin
        last_fall[g] = cyc;
        if (hi_run[g] != div_of(g)) bad_high[g]++;
      end
      if (sclk[g]) hi_run[g]++;
      else hi_run[g] = 0;
      if (prev_ss[g] && ss[g] && (sclk[g] !== prev_sclk[g])) bad_edge[g]++;
      if (done[g]) begin
        done_cnt[g]++;
        check_eq($sformatf("done_with_ss_high%0d", g), ss[g], 1);
        check_eq($sformatf("done_expected%0d", g), exp_q[g].size() > 0, 1);
        if (exp_q[g].size() > 0)
          check_eq($sformatf("rx_data%0d", g), rx_data[g], exp_q[g].pop_front());
      end
      prev_ss[g]   = ss[g];
      prev_sclk[g] = sclk[g];
    end
  end

  task automatic clear_stats(int g);
    rises[g] = 0; done_cnt[g] = 0; bad_edge[g] = 0; bad_high[g] = 0;
    first_rise[g] = 0; last_fall[g] = 0; mosi_seq[g] = 8'h00;
  endtask

  task automatic send(int g, logic [7:0] d, logic [7:0] e, bit push);
    @(negedge clk);
    tx_data[g] = d;
    start[g]   = 1'b1;
    if (push) exp_q[g].push_back(e);
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_idle(int g, int budget);
    int i = 0;
    while (busy[g] && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq($sformatf("idle_within_budget%0d", g), busy[g], 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      ss_low_run[g] = 0; last_ss_low[g] = 0; ss_high_run[g] = 0; last_ss_high[g] = 0;
      busy_run[g] = 0; last_busy[g] = 0; hi_run[g] = 0;
      prev_ss[g] = 1'b1; prev_sclk[g] = 1'b0; tx_data[g] = 8'h00;
      clear_stats(g);
    end
    p_miso = 1'b0; p_tx = 8'h00; p_rx = 8'h00;
    rst = 3'b111; start = 3'b000;
    repeat (3) @(negedge clk);
    rst = 3'b000;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("rst_ss%0d", g), ss[g], 1);
      check_eq($sformatf("rst_sclk%0d", g), sclk[g], 0);
      check_eq($sformatf("rst_busy%0d", g), busy[g], 0);
      check_eq($sformatf("rst_done%0d", g), done[g], 0);
      check_eq($sformatf("rst_mosi%0d", g), mosi[g], 0);
      check_eq($sformatf("rst_rx%0d", g), rx_data[g], 0);
    end

    // loopback, CLK_DIV=2, A5
    clear_stats(0);
    send(0, 8'hA5, 8'hA5, 1'b1);
    wait_idle(0, 400);
    check_eq("t1_ss_low", last_ss_low[0], 36);
    check_eq("t1_rises", rises[0], 8);
    check_eq("t1_mosi_seq", mosi_seq[0], 8'hA5);
    check_eq("t1_busy_len", last_busy[0], 38);
    check_eq("t1_done_cnt", done_cnt[0], 1);
    check_eq("t1_sclk_high", bad_high[0], 0);
    check_eq("t1_edge_ss_high", bad_edge[0], 0);
    check_eq("t1_sclk_span", last_fall[0] - first_rise[0], 15 * 2);

    // peripheral model, CLK_DIV=4
    clear_stats(1);
    send(1, 8'h5A, 8'h3C, 1'b1);
    wait_idle(1, 400);
    check_eq("t2_periph_rx", p_rx, 8'h5A);
    check_eq("t2_ss_low", last_ss_low[1], 72);
    check_eq("t2_done_cnt", done_cnt[1], 1);
    check_eq("t2_rises", rises[1], 8);
    check_eq("t2_busy_len", last_busy[1], 76);

    // start held high: back-to-back frames, tx_data changed mid-frame
    clear_stats(0);
    @(negedge clk);
    start[0] = 1'b1; tx_data[0] = 8'h01;
    exp_q[0].push_back(8'h01);
    exp_q[0].push_back(8'hFF);
    repeat (10) @(negedge clk);
    tx_data[0] = 8'hFF;
    for (int i = 0; i < 200 && !(done_cnt[0] >= 1 && ss[0] == 1'b0); i++) @(negedge clk);
    check_eq("t3_second_accept", ss[0], 0);
    start[0] = 1'b0;
    wait_idle(0, 400);
    check_eq("t3_done_cnt", done_cnt[0], 2);
    check_eq("t3_ss_gap", last_ss_high[0], 2);
    check_eq("t3_rises", rises[0], 16);
    check_eq("t3_edge_ss_high", bad_edge[0], 0);

    // start pulsed during SHIFT is ignored
    clear_stats(0);
    send(0, 8'h69, 8'h69, 1'b1);
    repeat (12) @(negedge clk);
    start[0] = 1'b1; tx_data[0] = 8'h00;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0, 400);
    check_eq("t4_done_cnt", done_cnt[0], 1);
    check_eq("t4_rises", rises[0], 8);
    check_eq("t4_edge_ss_high", bad_edge[0], 0);

    // reset during the 4th bit aborts the frame
    send(0, 8'h96, 8'h00, 1'b0);
    repeat (16) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check_eq("t5_ss", ss[0], 1);
    check_eq("t5_sclk", sclk[0], 0);
    check_eq("t5_busy", busy[0], 0);
    check_eq("t5_rx", rx_data[0], 8'h00);
    clear_stats(0);
    repeat (60) @(negedge clk);
    check_eq("t5_no_done", done_cnt[0], 0);
    send(0, 8'h3E, 8'h3E, 1'b1);
    wait_idle(0, 400);
    check_eq("t5_fresh_done", done_cnt[0], 1);
    check_eq("t5_fresh_ss_low", last_ss_low[0], 36);

    // CLK_DIV=1 loopback
    clear_stats(2);
    send(2, 8'hC3, 8'hC3, 1'b1);
    wait_idle(2, 200);
    check_eq("t6_ss_low", last_ss_low[2], 18);
    check_eq("t6_rises", rises[2], 8);
    check_eq("t6_sclk_high", bad_high[2], 0);
    check_eq("t6_sclk_span", last_fall[2] - first_rise[2], 15);
    check_eq("t6_busy_len", last_busy[2], 19);
    check_eq("t6_mosi_seq", mosi_seq[2], 8'hC3);

    for (int g = 0; g < 3; g++)
      check_eq($sformatf("queue_drained%0d", g), exp_q[g].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
Single-byte SPI controller (master) that drives the SPI_Peripheral from the host side of the GPU test harness. It uses SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8 bits per frame. sclk is generated internally from the system clock. On a start request it frames one byte with ss, shifts tx_data out on mosi, captures the returned byte from miso, then reports completion with a one-cycle done pulse.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; legal range >= 1; sclk period = 2*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  transfer request; sampled only in IDLE
tx_data  input  8  byte to transmit; latched when start is accepted
rx_data  output  8  last received byte; valid from the done cycle, held until the next done
busy  output  1  high while a transaction (including the trailing gap) is in progress
done  output  1  one-cycle pulse when rx_data is updated
ss  output  1  slave select, active-low
sclk  output  1  SPI clock, idles low
mosi  output  1  controller data out
miso  input  1  peripheral data in

Behaviour:
- All outputs are registered.
- Reset, synchronous and active-high, overrides everything including a transfer in progress. On the same edge: state=IDLE, ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00, shift registers and counters cleared. Nothing is emitted after reset releases.
- States and transitions:
  - IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - One internal divider counter counts 0..CLK_DIV-1 and advances the phase on terminal count.
  - A 4-bit half-cycle counter runs 0..15 in SHIFT.
- IDLE: ss=1, sclk=0, busy=0. If start=1 at an edge, on that same edge:
  - latch tx_data into the tx shift register;
  - set mosi=tx_data[7], ss=0, busy=1;
  - enter SETUP.
- SETUP: lasts CLK_DIV cycles with sclk=0, giving mosi setup time before the first rising edge.
- SHIFT: 16 half-periods of CLK_DIV cycles each.
  - Even half-period end: sclk 0->1. On the same clk edge, miso is shifted into the LSB of the rx shift register.
  - Odd half-period end: sclk 1->0. On the same clk edge, the tx shift register moves left and mosi takes the next bit.
  - After the 8th falling edge, mosi holds the last driven value and the state goes to HOLD.
- HOLD: CLK_DIV cycles with sclk=0 and ss=0, then:
  - ss=1;
  - rx_data <= rx shift register;
  - done=1 for exactly this one cycle;
  - enter GAP.
- GAP: CLK_DIV cycles with ss=1 and busy=1, guaranteeing minimum ss-high time. Then IDLE, where busy=0.
- Timing summary:
  - ss low for exactly 18*CLK_DIV cycles.
  - First sclk rise occurs CLK_DIV cycles after ss falls.
  - Exactly 8 sclk pulses per frame, each high for CLK_DIV cycles.
  - busy high for 19*CLK_DIV cycles after the accepting edge.
- start while busy=1 is ignored; no queuing.
- start held high continuously produces back-to-back frames. Each new frame is accepted in the first IDLE cycle after GAP.
- Changes on tx_data after acceptance have no effect on the frame in progress.
- mosi is only guaranteed meaningful while ss=0.
- No sclk edge ever occurs while ss=1.
- CLK_DIV=1 must work; each phase is then a single cycle.
- Width rules: counters are sized $clog2(CLK_DIV)+1 bits minimum. No arithmetic overflow is permitted for any legal CLK_DIV.

Test Plan:
- Loopback (miso tied to mosi), CLK_DIV=2, tx_data=8'hA5, pulse start -> ss low exactly 36 cycles; 8 sclk rises; mosi sequence 1,0,1,0,0,1,0,1; rx_data=8'hA5 in the done cycle; busy low 38 cycles after accept.
- Behavioural mode-0 peripheral model returning 8'h3C while the controller sends 8'h5A, CLK_DIV=4 -> model receives 8'h5A; rx_data=8'h3C; done high exactly one cycle, coincident with ss rising.
- start held high, tx_data=8'h01 then 8'hFF -> two frames; ss high exactly CLK_DIV cycles between them; second frame shifts 8'hFF even if tx_data changed mid-first-frame.
- start pulsed during SHIFT of a frame -> ignored; exactly one done; no extra sclk edges.
- rst asserted one cycle during the 4th bit -> next edge: ss=1, sclk=0, busy=0, rx_data=8'h00; no done ever issued for the aborted frame; a fresh frame afterwards completes correctly.
- CLK_DIV=1, tx_data=8'hC3 loopback -> ss low 18 cycles; sclk toggles every cycle during SHIFT; rx_data=8'hC3.
